// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised 'locked', retries
// failed attempts and releases the downstream reset only after lock has stayed up long enough.
//
// state     | meaning
// RESET_PLL | PLL held in reset for RST_PULSE_CYCLES
// WAIT_LOCK | waiting for locked_sync, bounded by LOCK_TIMEOUT_CYCLES
// STABLE    | locked_sync must stay high for LOCK_STABLE_CYCLES
// RUN       | downstream logic released
// FAULT     | all attempts exhausted; PLL held in reset until sw_relock or rst_n
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       sw_relock_i,
  output logic       pll_rst_o,
  output logic       user_rst_n_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_sync;
  logic                   pll_rst_q, user_rst_n_q, ready_q, fault_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
  end

  assign locked_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (sw_relock_i) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: if (cnt_q == RST_TC) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (locked_sync) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_TC) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        // A lock drop always wins over the stable-window terminal count.
        S_STABLE: begin
          if (!locked_sync)            state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_TC) state_d = S_RUN;
        end
        S_RUN: begin
          if (!locked_sync) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RESET_PLL;
      endcase
    end

    // Relock while already in RESET_PLL must still restart the pulse.
    if (sw_relock_i || (state_d != state_q))             cnt_d = '0;
    else if ((state_q == S_RUN) || (state_q == S_FAULT)) cnt_d = cnt_q;
    else                                                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      user_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      user_rst_n_q <= (state_d == S_RUN);
      ready_q      <= (state_d == S_RUN);
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign user_rst_n_o = user_rst_n_q;
  assign ready_o      = ready_q;
  assign fault_o      = fault_q;
  assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues each expected output change with the
// refclk cycle on which it must appear; a monitor pops and checks whenever the outputs change.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_relock = 1'b0;
  logic       pll_rst, user_rst_n, ready, fault;
  logic [3:0] retry_cnt;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  // Output vector: {pll_rst, user_rst_n, ready, fault, retry_cnt[3:0]}
  typedef struct {
    logic [7:0] vec;
    int         at;
    string      name;
  } exp_t;
  exp_t exp_q[$];

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked_i(pll_locked),
    .sw_relock_i (sw_relock),
    .pll_rst_o   (pll_rst),
    .user_rst_n_o(user_rst_n),
    .ready_o     (ready),
    .fault_o     (fault),
    .retry_cnt_o (retry_cnt)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic logic [7:0] outs();
    return {pll_rst, user_rst_n, ready, fault, retry_cnt};
  endfunction

  task automatic expect_ev(input logic [7:0] v, input int at, input string nm);
    exp_t e;
    e.vec  = v;
    e.at   = at;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge refclk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge refclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d events pending (next %s), required 0", exp_q.size(), exp_q[0].name);
      exp_q.delete();
    end
  endtask

  initial begin : monitor
    logic [7:0] prev, cur;
    exp_t e;
    prev = 8'hFF;
    forever begin
      @(posedge refclk);
      #1;
      cur = outs();
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got %02h at cyc %0d, required no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.vec || (e.at >= 0 && cyc != e.at)) begin
            n_bad++;
            $display("FAIL %s: got %02h at cyc %0d, required %02h at cyc %0d",
                     e.name, cur, cyc, e.vec, e.at);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #40000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int k, m, d, f, q;

    // Reset state
    expect_ev(8'h80, -1, "reset_state");
    #2 rst_n = 1'b0;
    wait_to(3);

    // 1: release, lock 3 cycles after pll_rst falls, RUN after stable window
    k = cyc;
    rst_n = 1'b1;
    expect_ev(8'h00, k + 4, "s1_pll_rst_fall");
    expect_ev(8'h60, k + 18, "s1_run");
    wait_to(k + 7);
    pll_locked = 1'b1;
    drain(60);
    repeat (10) @(negedge refclk);

    // 4: lock lost in RUN, then restored
    m = cyc;
    pll_locked = 1'b0;
    expect_ev(8'h80, m + 3, "s4_relock_rst");
    expect_ev(8'h00, m + 7, "s4_pll_rst_fall");
    expect_ev(8'h60, m + 18, "s4_run");
    wait_to(m + 7);
    pll_locked = 1'b1;
    drain(60);
    repeat (5) @(negedge refclk);

    // 3: 2-cycle lock glitch while STABLE at cnt=5 restarts the window, no PLL reset
    m = cyc;
    pll_locked = 1'b0;
    expect_ev(8'h80, m + 3, "s3_relock_rst");
    expect_ev(8'h00, m + 7, "s3_pll_rst_fall");
    wait_to(m + 7);
    pll_locked = 1'b1;
    d = m + 15;
    expect_ev(8'h60, d + 13, "s3_run_after_glitch");
    wait_to(d);
    pll_locked = 1'b0;
    wait_to(d + 2);
    pll_locked = 1'b1;
    drain(60);
    repeat (5) @(negedge refclk);

    // 2: lock never arrives -> three attempts then FAULT, held
    m = cyc;
    pll_locked = 1'b0;
    expect_ev(8'h80, m + 3,  "s2_attempt0_rst");
    expect_ev(8'h00, m + 7,  "s2_attempt0_wait");
    expect_ev(8'h81, m + 27, "s2_attempt1_rst");
    expect_ev(8'h01, m + 31, "s2_attempt1_wait");
    expect_ev(8'h82, m + 51, "s2_attempt2_rst");
    expect_ev(8'h02, m + 55, "s2_attempt2_wait");
    expect_ev(8'h92, m + 75, "s2_fault");
    drain(120);
    repeat (30) @(negedge refclk);

    // 5: sw_relock out of FAULT
    f = cyc;
    expect_ev(8'h80, f + 1,  "s5_relock_rst");
    expect_ev(8'h00, f + 5,  "s5_pll_rst_fall");
    expect_ev(8'h60, f + 16, "s5_run");
    sw_relock = 1'b1;
    @(negedge refclk);
    sw_relock = 1'b0;
    wait_to(f + 5);
    pll_locked = 1'b1;
    drain(60);
    repeat (5) @(negedge refclk);

    // 6: rst_n asserted in WAIT_LOCK with cnt=10, retry_cnt=1
    m = cyc;
    pll_locked = 1'b0;
    expect_ev(8'h80, m + 3,  "s6_relock_rst");
    expect_ev(8'h00, m + 7,  "s6_attempt0_wait");
    expect_ev(8'h81, m + 27, "s6_attempt1_rst");
    expect_ev(8'h01, m + 31, "s6_attempt1_wait");
    wait_to(m + 41);
    expect_ev(8'h80, m + 42, "s6_async_reset");
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs() !== 8'h80) begin
      n_bad++;
      $display("FAIL s6_reset_immediate: got %02h, required 80", outs());
    end
    wait_to(m + 44);
    q = cyc;
    rst_n = 1'b1;
    expect_ev(8'h00, q + 4,  "s6_pll_rst_fall");
    expect_ev(8'h60, q + 18, "s6_run");
    wait_to(q + 7);
    pll_locked = 1'b1;
    drain(60);
    repeat (10) @(negedge refclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
